wb_gpio_arbiter: RTL and testbench
==================================

// Module: wb_gpio_arbiter
// PURPOSE
//  Two-master round-robin Wishbone arbiter that shares one simple_gpio-style slave port.
//  Typical masters: host bus bridge (m0) and an on-chip sequencer (m1).
//  Ownership is granted per bus cycle and held until the owner drops cyc.
//  The next grant waits until the slave's held-high ack has cleared.
//  A watchdog releases the slave if the owner stalls with no ack.
// PARAMETERS
//  DATA_WIDTH  32   data bus width
//  ADDR_WIDTH  32   address bus width
//  TIMEOUT     255  cycles stb may wait for ack before forced release (1..255)
// PORTS
//  clk           in   1   system clock
//  rst           in   1   asynchronous, active-high reset
//  m{0,1}_cyc_i  in   1   master cycle request
//  m{0,1}_stb_i  in   1   master strobe
//  m{0,1}_we_i   in   1   master write enable
//  m{0,1}_adr_i  in   AW  master address
//  m{0,1}_dat_i  in   DW  master write data
//  m{0,1}_dat_o  out  DW  read data; zero when not granted
//  m{0,1}_ack_o  out  1   ack; zero when not granted
//  m{0,1}_int_o  out  1   slave interrupt, fanned out to both masters
//  s_cyc_o       out  1   slave cycle
//  s_stb_o       out  1   slave strobe
//  s_we_o        out  1   slave write enable
//  s_adr_o       out  AW  slave address
//  s_dat_o       out  DW  slave write data
//  s_dat_i       in   DW  slave read data
//  s_ack_i       in   1   slave ack (registered; held until stb falls)
//  s_int_i       in   1   slave interrupt
//  grant_o       out  2   one-hot current owner (00 = none)
//  timeout_o     out  1   one-cycle pulse on watchdog release
// BEHAVIOUR
//  States: IDLE, OWN0, OWN1, DRAIN.
//  Reset: state=IDLE, grant_o=00, last=1 (m0 wins the first tie), wdog=0, timeout_o=0.
//  Slave outputs are 0 while no master is granted.
//  IDLE:
//   - Only mN_cyc_i high -> OWNN on the next clock.
//   - Both high -> grant the master != last, then set last to it.
//   - Grant latency is one clock from cyc to s_cyc_o.
//  OWNN:
//   - s_* outputs mux combinationally from mN.
//   - mN_ack_o = s_ack_i; mN_dat_o = s_dat_i; the other master sees ack=0, dat=0.
//   - Leave to DRAIN when mN_cyc_i = 0; the grant drops in the same clock.
//  DRAIN:
//   - s_cyc_o = s_stb_o = 0. Stay while s_ack_i = 1.
//   - Go to IDLE when s_ack_i = 0. This guarantees no stale ack reaches the next owner.
//  Watchdog (wdog):
//   - Counts while OWNN and s_stb_o = 1 and s_ack_i = 0. Clears otherwise.
//   - Reaching TIMEOUT: go to DRAIN, pulse timeout_o for one clock, clear wdog.
//   - The stalled master then sees ack=0 until it drops cyc and re-requests.
//  A new request in the same clock as a release is not granted before passing DRAIN/IDLE.
//  m0_int_o = m1_int_o = s_int_i, combinational and independent of grant.
//  Async reset mid-cycle: all outputs return to reset values immediately; no ack leaks out.
// TESTING
//  1. m0 writes 0x0000_00FF to addr 1 alone -> s_cyc_o 1 clk after m0_cyc_i; m0_ack_o follows s_ack_i; m1_ack_o=0.
//  2. m0 and m1 raise cyc in the same clock from reset -> grant_o=01; after m0 drops cyc, DRAIN, then grant_o=10.
//  3. Both requesting continuously (back-to-back single cycles) -> grants alternate 01,10,01,10.
//  4. Slave holds ack=1 for 2 clocks after owner drops cyc -> arbiter stays in DRAIN; m1 is not granted until ack=0.
//  5. TIMEOUT=8, slave never acks -> after 8 stall clocks timeout_o pulses once; s_cyc_o=0; grant passes to the waiting master.
//  6. Assert rst mid-read while granted -> grant_o, s_cyc_o and mN_ack_o go to 0 without waiting for clk; first grant after release goes to m0.

Source files
------------

// File: rtl/wb_gpio_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of a single simple_gpio-style slave.
// Ownership is held per bus cycle; a drain state keeps a held-high slave ack from leaking.
module wb_gpio_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [DATA_WIDTH-1:0] m0_dat_i,
    output logic [DATA_WIDTH-1:0] m0_dat_o,
    output logic                  m0_ack_o,
    output logic                  m0_int_o,

    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [DATA_WIDTH-1:0] m1_dat_i,
    output logic [DATA_WIDTH-1:0] m1_dat_o,
    output logic                  m1_ack_o,
    output logic                  m1_int_o,

    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [DATA_WIDTH-1:0] s_dat_o,
    input  logic [DATA_WIDTH-1:0] s_dat_i,
    input  logic                  s_ack_i,
    input  logic                  s_int_i,

    output logic [1:0]            grant_o,
    output logic                  timeout_o
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StOwn0  = 2'd1;
    localparam logic [1:0] StOwn1  = 2'd2;
    localparam logic [1:0] StDrain = 2'd3;

    localparam logic [7:0] WdogLast = 8'(TIMEOUT - 1);

    logic [1:0] state_q, state_d;
    logic       last_q, last_d;
    logic [7:0] wdog_q, wdog_d;
    logic       timeout_q, timeout_d;
    // A master released by the watchdog stays locked out until it drops cyc.
    logic [1:0] blk_q, blk_d;

    logic req0, req1, stall;

    assign req0  = m0_cyc_i & ~blk_q[0];
    assign req1  = m1_cyc_i & ~blk_q[1];
    assign stall = ((state_q == StOwn0) || (state_q == StOwn1)) && s_stb_o && !s_ack_i;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        wdog_d    = 8'd0;
        timeout_d = 1'b0;
        blk_d     = blk_q & {m1_cyc_i, m0_cyc_i};
        unique case (state_q)
            StIdle: begin
                if (req0 && req1) begin
                    if (last_q) begin
                        state_d = StOwn0;
                        last_d  = 1'b0;
                    end else begin
                        state_d = StOwn1;
                        last_d  = 1'b1;
                    end
                end else if (req0) begin
                    state_d = StOwn0;
                    last_d  = 1'b0;
                end else if (req1) begin
                    state_d = StOwn1;
                    last_d  = 1'b1;
                end
            end
            StOwn0: begin
                if (!m0_cyc_i) begin
                    state_d = StDrain;
                end else if (stall) begin
                    if (wdog_q == WdogLast) begin
                        state_d   = StDrain;
                        timeout_d = 1'b1;
                        blk_d[0]  = 1'b1;
                    end else begin
                        wdog_d = wdog_q + 8'd1;
                    end
                end
            end
            StOwn1: begin
                if (!m1_cyc_i) begin
                    state_d = StDrain;
                end else if (stall) begin
                    if (wdog_q == WdogLast) begin
                        state_d   = StDrain;
                        timeout_d = 1'b1;
                        blk_d[1]  = 1'b1;
                    end else begin
                        wdog_d = wdog_q + 8'd1;
                    end
                end
            end
            StDrain: begin
                if (!s_ack_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            last_q    <= 1'b1;
            wdog_q    <= 8'd0;
            timeout_q <= 1'b0;
            blk_q     <= 2'b00;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
            blk_q     <= blk_d;
        end
    end

    // Output mux is purely a function of state_q, so async reset clears it at once.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m0_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_dat_o = '0;
        grant_o  = 2'b00;
        unique case (state_q)
            StOwn0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = s_ack_i;
                m0_dat_o = s_dat_i;
                grant_o  = 2'b01;
            end
            StOwn1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i;
                m1_dat_o = s_dat_i;
                grant_o  = 2'b10;
            end
            StIdle, StDrain: ;
            default: ;
        endcase
    end

    assign m0_int_o  = s_int_i;
    assign m1_int_o  = s_int_i;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_wb_gpio_arbiter.sv
// Table-driven bench for wb_gpio_arbiter: vectors applied at negedge, outputs checked
// 1 time unit after the following posedge through an expected-results queue.
module tb_wb_gpio_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam logic [AW-1:0] A0 = 32'h0000_0001;
    localparam logic [AW-1:0] A1 = 32'h0000_0002;
    localparam logic [DW-1:0] D0 = 32'h0000_00FF;
    localparam logic [DW-1:0] D1 = 32'h0000_00AB;
    localparam logic [DW-1:0] SD = 32'h1234_5678;

    typedef struct {
        logic       rst;
        logic       c0;
        logic       c1;
        logic       ack;
        logic       irq;
        logic [1:0] grant;
        logic       scyc;
        logic       ack0;
        logic       ack1;
        logic       tmo;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [AW-1:0] m0_adr, m1_adr, s_adr;
    logic [DW-1:0] m0_dw, m1_dw, m0_dr, m1_dr, s_dw, s_dr;
    logic m0_ack, m1_ack, m0_int, m1_int;
    logic s_cyc, s_stb, s_we, s_ack, s_int;
    logic [1:0] grant;
    logic timeout;

    int n_vec = 0;
    int n_miss = 0;
    vec_t tbl[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    wb_gpio_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .TIMEOUT   (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_cyc_i (m0_cyc),
        .m0_stb_i (m0_stb),
        .m0_we_i  (m0_we),
        .m0_adr_i (m0_adr),
        .m0_dat_i (m0_dw),
        .m0_dat_o (m0_dr),
        .m0_ack_o (m0_ack),
        .m0_int_o (m0_int),
        .m1_cyc_i (m1_cyc),
        .m1_stb_i (m1_stb),
        .m1_we_i  (m1_we),
        .m1_adr_i (m1_adr),
        .m1_dat_i (m1_dw),
        .m1_dat_o (m1_dr),
        .m1_ack_o (m1_ack),
        .m1_int_o (m1_int),
        .s_cyc_o  (s_cyc),
        .s_stb_o  (s_stb),
        .s_we_o   (s_we),
        .s_adr_o  (s_adr),
        .s_dat_o  (s_dw),
        .s_dat_i  (s_dr),
        .s_ack_i  (s_ack),
        .s_int_i  (s_int),
        .grant_o  (grant),
        .timeout_o(timeout)
    );

    function automatic vec_t mk(logic r, logic c0, logic c1, logic ack, logic irq,
                                logic [1:0] g, logic scyc, logic a0, logic a1, logic tmo);
        vec_t v;
        v.rst = r; v.c0 = c0; v.c1 = c1; v.ack = ack; v.irq = irq;
        v.grant = g; v.scyc = scyc; v.ack0 = a0; v.ack1 = a1; v.tmo = tmo;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst    = v.rst;
        m0_cyc = v.c0;
        m0_stb = v.c0;
        m1_cyc = v.c1;
        m1_stb = v.c1;
        s_ack  = v.ack;
        s_int  = v.irq;
    endtask

    task automatic check_pop(input string name);
        vec_t e;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_sdw, e_d0, e_d1;
        logic e_we;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_miss++;
            $display("FAIL %s: scoreboard empty, got nothing to compare against", name);
            return;
        end
        e = exp_q.pop_front();
        e_adr = (e.grant == 2'b01) ? A0 : (e.grant == 2'b10) ? A1 : '0;
        e_sdw = (e.grant == 2'b01) ? D0 : (e.grant == 2'b10) ? D1 : '0;
        e_we  = (e.grant == 2'b01);
        e_d0  = e.grant[0] ? SD : '0;
        e_d1  = e.grant[1] ? SD : '0;
        if (grant !== e.grant || s_cyc !== e.scyc || s_stb !== e.scyc || m0_ack !== e.ack0 ||
            m1_ack !== e.ack1 || timeout !== e.tmo || m0_int !== e.irq || m1_int !== e.irq ||
            s_adr !== e_adr || s_dw !== e_sdw || s_we !== e_we || m0_dr !== e_d0 ||
            m1_dr !== e_d1) begin
            n_miss++;
            $display("FAIL %s: got grant=%b cyc=%b stb=%b ack0=%b ack1=%b tmo=%b int=%b%b adr=%h we=%b dat0=%h dat1=%h sdat=%h; want grant=%b cyc=%b ack0=%b ack1=%b tmo=%b int=%b adr=%h we=%b dat0=%h dat1=%h sdat=%h",
                     name, grant, s_cyc, s_stb, m0_ack, m1_ack, timeout, m0_int, m1_int,
                     s_adr, s_we, m0_dr, m1_dr, s_dw, e.grant, e.scyc, e.ack0, e.ack1, e.tmo,
                     e.irq, e_adr, e_we, e_d0, e_d1, e_sdw);
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        @(negedge clk);
        drive(v);
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        check_pop(name);
    endtask

    initial begin
        m0_we = 1'b1; m1_we = 1'b0;
        m0_adr = A0; m1_adr = A1; m0_dw = D0; m1_dw = D1; s_dr = SD;
        rst = 1'b1; m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; s_ack = 0; s_int = 0;

        //              rst c0 c1 ack irq grant scyc a0 a1 tmo
        // m0 alone: one-clock grant latency, ack follows slave, then drain
        tbl.push_back(mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 2'b01, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 2'b01, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0));
        // tie from reset goes to m0; held ack keeps m1 waiting in drain
        tbl.push_back(mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 2'b01, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 2'b01, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 2'b00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 2'b00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 2'b00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 2'b10, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 2'b10, 1, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 2'b00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0));
        // round robin under contention: 01 then 10
        tbl.push_back(mk(0, 1, 1, 0, 0, 2'b01, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 2'b01, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 2'b00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 2'b10, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 1, 2'b10, 1, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 2'b00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0));
        // watchdog: m0 stalls 8 clocks, pulse, m1 takes over, m0 locked out until cyc drops
        tbl.push_back(mk(0, 1, 1, 0, 0, 2'b01, 1, 0, 0, 0));
        for (int i = 0; i < 7; i++) tbl.push_back(mk(0, 1, 1, 0, 0, 2'b01, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 2'b00, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 2'b10, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 2'b10, 1, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 2'b00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 2'b01, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

        // async reset in the middle of a granted read with ack high
        run_vec(mk(0, 1, 0, 0, 0, 2'b01, 1, 0, 0, 0), "rd_grant");
        run_vec(mk(0, 1, 0, 1, 0, 2'b01, 1, 1, 0, 0), "rd_ack");
        #2;
        begin
            vec_t v;
            v = mk(1, 1, 0, 1, 0, 2'b00, 0, 0, 0, 0);
            drive(v);
            exp_q.push_back(v);
            #1;
            check_pop("async_rst");
        end
        run_vec(mk(1, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0), "rst_hold");
        run_vec(mk(0, 1, 1, 0, 0, 2'b01, 1, 0, 0, 0), "post_rst_m0");
        run_vec(mk(0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0), "post_rst_drain");
        run_vec(mk(0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0), "post_rst_idle");
        run_vec(mk(0, 0, 1, 0, 0, 2'b10, 1, 0, 0, 0), "post_rst_m1");
        run_vec(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0), "post_rst_done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
